// File: rtl/accumulator_sequencer_pkg.sv
// rtl/accumulator_sequencer_pkg.sv - shared sizing helpers and FSM encoding for the accumulator sequencer
package accumulator_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Output feature map edge after a valid (unpadded) convolution.
  function automatic int ifm_size_next(input int ifm_size, input int kernal_size);
    return ifm_size - kernal_size + 1;
  endfunction

  // Channel passes needed when each pass consumes `units` input channels.
  function automatic int num_passes(input int depth, input int units);
    int p;
    p = (depth + units - 1) / units;
    return (p < 1) ? 1 : p;
  endfunction

  // Bit width for a counter/select; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/accumulator_sequencer_write_delay.sv
// rtl/accumulator_sequencer_write_delay.sv - valid+payload delay line matching the Adder latency
module accu_write_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             pending
);

  generate
    if (DEPTH == 0) begin : g_wire
      // A combinational Adder needs no alignment; clock and reset are intentionally idle here.
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign pending   = 1'b0;
    end else begin : g_shift
      logic [DEPTH-1:0] vld;
      logic [WIDTH-1:0] dat [DEPTH];

      // Shift one stage per clock; reset empties the line so no stale write escapes.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld <= '0;
          for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
          vld[0] <= in_valid;
          dat[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[DEPTH-1];
      assign out_data  = dat[DEPTH-1];

      // Pending means something is still in flight beyond the stage writing this cycle.
      if (DEPTH == 1) begin : g_pend1
        assign pending = 1'b0;
      end else begin : g_pendn
        assign pending = |vld[DEPTH-2:0];
      end
    end
  endgenerate

endmodule

// File: rtl/accumulator_sequencer.sv
// rtl/accumulator_sequencer.sv - conv-layer accumulator sequencer: pixel/pass/filter stepping and partial-sum addressing
module accumulator_sequencer
  import accumulator_sequencer_pkg::*;
#(
  parameter int IFM_SIZE          = 14,
  parameter int IFM_DEPTH         = 3,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 16,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int ADDER_LATENCY     = 0,
  localparam int IFM_SIZE_NEXT               = ifm_size_next(IFM_SIZE, KERNAL_SIZE),
  localparam int NUM_PIXELS                  = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
  localparam int NUM_PASSES                  = num_passes(IFM_DEPTH, NUMBER_OF_UNITS),
  localparam int ADDRESS_SIZE_NEXT_IFM       = clog2_min1(NUM_PIXELS),
  localparam int NUMBER_OF_BITS_SEL_IFM_NEXT = clog2_min1(NUMBER_OF_FILTERS),
  localparam int PASS_BITS                   = clog2_min1(NUM_PASSES)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   conv_valid,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   accu_enable,
  output logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] filter_sel,
  output logic [PASS_BITS-1:0]                   pass_idx,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]       rd_addr,
  output logic                                   wr_en,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]       wr_addr,
  output logic [NUMBER_OF_BITS_SEL_IFM_NEXT-1:0] wr_filter,
  output logic                                   wr_final
);

  localparam int AW = ADDRESS_SIZE_NEXT_IFM;
  localparam int SW = NUMBER_OF_BITS_SEL_IFM_NEXT;
  localparam int PW = PASS_BITS;
  localparam int PAYLOAD_W = AW + SW + 1;

  logic [1:0]    state;
  logic [AW-1:0] pix;
  logic [PW-1:0] pass;
  logic [SW-1:0] filt;

  logic accept, last_pix, last_pass, last_filt, pending;
  logic dly_valid, dly_last;
  logic [PAYLOAD_W-1:0] dly_data;

  assign accept    = (state == ST_RUN) && conv_valid;
  assign last_pix  = (pix == AW'(NUM_PIXELS - 1));
  assign last_pass = (pass == PW'(NUM_PASSES - 1));
  assign last_filt = (filt == SW'(NUMBER_OF_FILTERS - 1));

  // Layer-level control: run until the final element is accepted, then drain the Adder pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (accept && last_pix && last_pass && last_filt) state <= ST_DRAIN;
        ST_DRAIN: if (!pending) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Nested loop counters: pixel innermost, then channel pass, then filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix  <= '0;
      pass <= '0;
      filt <= '0;
    end else if (state == ST_IDLE && start) begin
      pix  <= '0;
      pass <= '0;
      filt <= '0;
    end else if (accept) begin
      if (last_pix) begin
        pix <= '0;
        if (last_pass) begin
          pass <= '0;
          filt <= last_filt ? '0 : filt + SW'(1);
        end else begin
          pass <= pass + PW'(1);
        end
      end else begin
        pix <= pix + AW'(1);
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign accu_enable = (pass != '0);
  assign rd_addr     = pix;
  assign filter_sel  = filt;
  assign pass_idx    = pass;

  accu_write_delay #(
    .DEPTH (ADDER_LATENCY),
    .WIDTH (PAYLOAD_W)
  ) u_write_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_data   ({pix, filt, last_pass}),
    .out_valid (dly_valid),
    .out_data  (dly_data),
    .pending   (pending)
  );

  assign wr_en     = dly_valid;
  assign wr_addr   = dly_data[PAYLOAD_W-1 -: AW];
  assign wr_filter = dly_data[SW:1];
  assign dly_last  = dly_data[0];
  // Gate with valid so an idle single-pass layer never shows a stray final flag.
  assign wr_final  = dly_valid & dly_last;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb/tb_accumulator_sequencer.sv - directed scoreboard bench for accumulator_sequencer
module tb_accumulator_sequencer;

  typedef struct packed {
    int         due;
    logic [1:0] addr;
    logic       filt;
    logic       fin;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic start_a = 1'b0, cv_a = 1'b0;
  logic busy_a, done_a, accu_enable_a, filter_sel_a, pass_idx_a, wr_en_a, wr_filter_a, wr_final_a;
  logic [1:0] rd_addr_a, wr_addr_a;

  logic start_b = 1'b0, cv_b = 1'b0;
  logic busy_b, done_b, accu_enable_b, filter_sel_b, pass_idx_b, wr_en_b, wr_filter_b, wr_final_b;
  logic [1:0] rd_addr_b, wr_addr_b;

  accumulator_sequencer #(
    .IFM_SIZE(6), .IFM_DEPTH(6), .KERNAL_SIZE(5), .NUMBER_OF_FILTERS(2),
    .NUMBER_OF_UNITS(3), .ADDER_LATENCY(2)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .conv_valid(cv_a),
    .busy(busy_a), .done(done_a), .accu_enable(accu_enable_a),
    .filter_sel(filter_sel_a), .pass_idx(pass_idx_a), .rd_addr(rd_addr_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_filter(wr_filter_a), .wr_final(wr_final_a)
  );

  accumulator_sequencer #(
    .IFM_SIZE(6), .IFM_DEPTH(3), .KERNAL_SIZE(5), .NUMBER_OF_FILTERS(2),
    .NUMBER_OF_UNITS(3), .ADDER_LATENCY(0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .conv_valid(cv_b),
    .busy(busy_b), .done(done_b), .accu_enable(accu_enable_b),
    .filter_sel(filter_sel_b), .pass_idx(pass_idx_b), .rd_addr(rd_addr_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_filter(wr_filter_b), .wr_final(wr_final_b)
  );

  wr_exp_t qa[$];
  wr_exp_t qb[$];
  int done_cnt_a = 0, done_cyc_a = -1, last_a = 0;
  int done_cnt_b = 0, done_cyc_b = -1, last_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-side scoreboard for dut_a: every wr_en must match the oldest expected write on its due cycle.
  always @(negedge clk) begin
    wr_exp_t e;
    if (wr_en_a) begin
      if (qa.size() == 0) chk("wr_unexpected_a", 32'(wr_en_a), 32'd0);
      else begin
        e = qa.pop_front();
        chk("wr_fields_a", 32'({wr_addr_a, wr_filter_a, wr_final_a}), 32'({e.addr, e.filt, e.fin}));
        chk("wr_cycle_a", cyc, e.due);
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      qa.delete(0);
      chk("wr_missing_a", 32'(wr_en_a), 32'd1);
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  end

  // Same scoreboard for the single-pass, zero-latency instance.
  always @(negedge clk) begin
    wr_exp_t e;
    if (wr_en_b) begin
      if (qb.size() == 0) chk("wr_unexpected_b", 32'(wr_en_b), 32'd0);
      else begin
        e = qb.pop_front();
        chk("wr_fields_b", 32'({wr_addr_b, wr_filter_b, wr_final_b}), 32'({e.addr, e.filt, e.fin}));
        chk("wr_cycle_b", cyc, e.due);
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      qb.delete(0);
      chk("wr_missing_b", 32'(wr_en_b), 32'd1);
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  // dut_a: 4 pixels, 2 passes, 2 filters -> element e has pix e%4, pass (e/4)%2, filter e/8.
  task automatic elem_a(input int e, input int gap);
    wr_exp_t x;
    int n;
    cv_a = 1'b1;
    x.due = cyc + 2; x.addr = 2'(e % 4); x.filt = 1'(e / 8); x.fin = (((e / 4) % 2) == 1);
    qa.push_back(x);
    @(negedge clk);
    chk("rd_addr_a", 32'(rd_addr_a), e % 4);
    chk("filter_sel_a", 32'(filter_sel_a), e / 8);
    chk("pass_idx_a", 32'(pass_idx_a), (e / 4) % 2);
    chk("accu_enable_a", 32'(accu_enable_a), (e / 4) % 2);
    chk("busy_run_a", 32'(busy_a), 32'd1);
    last_a = cyc;
    @(posedge clk); #1;
    cv_a = 1'b0;
    n = (e + 1) % 16;
    repeat (gap) begin
      @(negedge clk);
      chk("gap_rd_addr_a", 32'(rd_addr_a), n % 4);
      chk("gap_accu_enable_a", 32'(accu_enable_a), (n / 4) % 2);
      chk("gap_filter_sel_a", 32'(filter_sel_a), n / 8);
      @(posedge clk); #1;
    end
  endtask

  // dut_b: 4 pixels, 1 pass, 2 filters -> every write final, no partial-sum reads.
  task automatic elem_b(input int e);
    wr_exp_t x;
    cv_b = 1'b1;
    x.due = cyc; x.addr = 2'(e % 4); x.filt = 1'(e / 4); x.fin = 1'b1;
    qb.push_back(x);
    @(negedge clk);
    chk("rd_addr_b", 32'(rd_addr_b), e % 4);
    chk("filter_sel_b", 32'(filter_sel_b), e / 4);
    chk("accu_enable_b", 32'(accu_enable_b), 32'd0);
    last_b = cyc;
    @(posedge clk); #1;
    cv_b = 1'b0;
  endtask

  task automatic start_run_a();
    start_a = 1'b1;
    @(negedge clk);
    chk("busy_before_run_a", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic finish_a(input int done_before);
    repeat (6) @(posedge clk);
    #1;
    chk("done_count_a", done_cnt_a - done_before, 32'd1);
    chk("done_cycle_a", done_cyc_a, last_a + 3);
    chk("busy_after_a", 32'(busy_a), 32'd0);
    chk("writes_pending_a", qa.size(), 32'd0);
  endtask

  initial begin
    int d0;
    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_wr_en", 32'(wr_en_a), 32'd0);
    chk("rst_wr_final", 32'(wr_final_a), 32'd0);
    chk("rst_accu_enable", 32'(accu_enable_a), 32'd0);
    chk("rst_addrs", 32'({rd_addr_a, wr_addr_a, filter_sel_a, wr_filter_a, pass_idx_a}), 32'd0);
    chk("rst_wr_final_b", 32'(wr_final_b), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // back-to-back run: read sequence, write sequence and done timing
    d0 = done_cnt_a;
    start_run_a();
    for (int e = 0; e < 16; e++) elem_a(e, 0);
    finish_a(d0);

    // one valid every three cycles
    d0 = done_cnt_a;
    start_run_a();
    for (int e = 0; e < 16; e++) elem_a(e, 2);
    finish_a(d0);

    // conv_valid while idle must not move counters or write
    cv_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rd_addr", 32'(rd_addr_a), 32'd0);
      chk("idle_pass_idx", 32'(pass_idx_a), 32'd0);
      chk("idle_busy", 32'(busy_a), 32'd0);
      @(posedge clk); #1;
    end
    cv_a = 1'b0;
    // start again mid-run must not restart
    d0 = done_cnt_a;
    start_run_a();
    for (int e = 0; e < 6; e++) elem_a(e, 0);
    start_a = 1'b1;
    @(negedge clk);
    chk("restart_rd_addr", 32'(rd_addr_a), 32'd2);
    chk("restart_pass_idx", 32'(pass_idx_a), 32'd1);
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int e = 6; e < 16; e++) elem_a(e, 0);
    finish_a(d0);

    // reset mid-run, then a clean run
    start_run_a();
    for (int e = 0; e < 7; e++) elem_a(e, 0);
    reset = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_wr_en", 32'(wr_en_a), 32'd0);
    chk("midrst_rd_addr", 32'(rd_addr_a), 32'd0);
    chk("midrst_pass_idx", 32'(pass_idx_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_busy", 32'(busy_a), 32'd0);
    d0 = done_cnt_a;
    start_run_a();
    for (int e = 0; e < 16; e++) elem_a(e, 0);
    finish_a(d0);

    // single pass, zero Adder latency
    d0 = done_cnt_b;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int e = 0; e < 8; e++) elem_b(e);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count_b", done_cnt_b - d0, 32'd1);
    chk("done_cycle_b", done_cyc_b, last_b + 2);
    chk("busy_after_b", 32'(busy_b), 32'd0);
    chk("writes_pending_b", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
